// File: rtl/lcd_bus_responder_if.sv
// LCD bus plus buffer read port, grouped for the far-end controller model.
interface lcd_bus_responder_if;
  logic       lcdE_i;
  logic       lcdRs_i;
  logic       lcdRw_i;
  logic [3:0] lcdData_i;
  logic [6:0] rdAds_i;
  logic [7:0] rdData_o;
  logic       byteValid_o;
  logic       byteRs_o;
  logic [7:0] byte_o;
  logic       mode4_o;
  logic       dispOn_o;
  logic [6:0] cursorAds_o;
  logic       busyViol_o;
  logic       rwViol_o;
  logic       clearing_o;

  // Controller side: samples the bus, exposes buffer and status.
  modport slave (
    input  lcdE_i, lcdRs_i, lcdRw_i, lcdData_i, rdAds_i,
    output rdData_o, byteValid_o, byteRs_o, byte_o, mode4_o, dispOn_o,
           cursorAds_o, busyViol_o, rwViol_o, clearing_o
  );

  // Driver side: drives the bus, observes status.
  modport master (
    output lcdE_i, lcdRs_i, lcdRw_i, lcdData_i, rdAds_i,
    input  rdData_o, byteValid_o, byteRs_o, byte_o, mode4_o, dispOn_o,
           cursorAds_o, busyViol_o, rwViol_o, clearing_o
  );
endinterface

// File: rtl/lcd_bus_responder.sv
// HD44780-style far-end controller model: reassembles nibbles on E falls,
// decodes commands, keeps a 128-entry display buffer and flags busy abuse.
module lcd_bus_responder #(
  parameter int unsigned BUSY_SHORT = 2000,
  parameter int unsigned BUSY_LONG  = 82000
) (
  input logic                clk_i,
  input logic                reset_i,
  lcd_bus_responder_if.slave bus
);
  localparam int unsigned AdsW  = 7;
  localparam int unsigned BusyW = 17;
  localparam int unsigned Depth = 128;
  localparam logic [7:0]       SpaceChar = 8'h20;
  localparam logic [BusyW-1:0] BusyShort = BusyW'(BUSY_SHORT);
  localparam logic [BusyW-1:0] BusyLong  = BusyW'(BUSY_LONG);
  localparam logic [AdsW-1:0]  LastAds   = AdsW'(Depth - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic              eD, rsD, rwD;
  logic [3:0]        dataD;
  logic              phase;
  logic [3:0]        hiNib;
  logic              idInc;
  logic [BusyW-1:0]  busyCnt;
  logic [AdsW-1:0]   fillIdx;
  logic              pendValid;
  logic [AdsW-1:0]   pendAds;
  logic [7:0]        pendData;
  logic [7:0]        mem [Depth];

  logic              byteValid, byteRs, mode4, dispOn, busyViol, rwViol, clearing;
  logic [7:0]        byteOut, rdData;
  logic [AdsW-1:0]   cursor;

  logic              fall, byteDone, dataWr, memWe;
  logic [7:0]        byteNew, memDin;
  logic [AdsW-1:0]   memAds;

  // Next DDRAM address: two 40-char lines at 0x00-0x27 and 0x40-0x67.
  function automatic logic [AdsW-1:0] stepCursor(input logic [AdsW-1:0] a, input logic inc);
    logic [AdsW-1:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + AdsW'(1);
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - AdsW'(1);
    end
    return r;
  endfunction

  // Fall detect, byte assembly and single buffer write port arbitration.
  always_comb begin
    fall     = eD & ~bus.lcdE_i;
    byteDone = 1'b0;
    byteNew  = {dataD, 4'h0};
    memWe    = 1'b0;
    memAds   = fillIdx;
    memDin   = SpaceChar;
    if (fall && !rwD) begin
      if (!mode4) begin
        byteDone = 1'b1;
      end else if (phase) begin
        byteDone = 1'b1;
        byteNew  = {hiNib, dataD};
      end
    end
    dataWr = byteDone & rsD;
    // Fill first, then a deferred write, then a fresh one; a fresh write
    // that collides with a deferred one is queued behind it.
    if (state == CLEAR) begin
      memWe = 1'b1;
    end else if (pendValid) begin
      memWe  = 1'b1;
      memAds = pendAds;
      memDin = pendData;
    end else if (dataWr) begin
      memWe  = 1'b1;
      memAds = cursor;
      memDin = byteNew;
    end
    if (reset_i) memWe = 1'b0;
  end

  // Bus sampling, decode, busy counter and IDLE/CLEAR state machine.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      eD        <= 1'b0;
      rsD       <= 1'b0;
      rwD       <= 1'b0;
      dataD     <= 4'h0;
      phase     <= 1'b0;
      hiNib     <= 4'h0;
      idInc     <= 1'b1;
      busyCnt   <= '0;
      fillIdx   <= '0;
      pendValid <= 1'b0;
      pendAds   <= '0;
      pendData  <= 8'h00;
      byteValid <= 1'b0;
      byteRs    <= 1'b0;
      byteOut   <= 8'h00;
      mode4     <= 1'b0;
      dispOn    <= 1'b0;
      cursor    <= '0;
      busyViol  <= 1'b0;
      rwViol    <= 1'b0;
      clearing  <= 1'b0;
    end else begin
      eD        <= bus.lcdE_i;
      rsD       <= bus.lcdRs_i;
      rwD       <= bus.lcdRw_i;
      dataD     <= bus.lcdData_i;
      byteValid <= 1'b0;
      busyViol  <= 1'b0;
      rwViol    <= 1'b0;
      if (busyCnt != '0) busyCnt <= busyCnt - BusyW'(1);

      if (state == CLEAR) begin
        fillIdx <= fillIdx + AdsW'(1);
        if (fillIdx == LastAds) begin
          state    <= IDLE;
          clearing <= 1'b0;
        end
      end

      if (dataWr && (state == CLEAR || pendValid)) begin
        pendValid <= 1'b1;
        pendAds   <= cursor;
        pendData  <= byteNew;
      end else if (state != CLEAR && pendValid) begin
        pendValid <= 1'b0;
      end

      if (fall) begin
        busyViol <= (busyCnt != '0);
        rwViol   <= rwD;
        if (mode4) begin
          phase <= ~phase;
          if (!rwD && !phase) hiNib <= dataD;
        end
      end

      if (byteDone) begin
        byteValid <= 1'b1;
        byteRs    <= rsD;
        byteOut   <= byteNew;
        busyCnt   <= BusyShort;
        if (rsD) begin
          cursor <= stepCursor(cursor, idInc);
        end else if (byteNew[7]) begin
          cursor <= byteNew[6:0];
        end else if (byteNew[6]) begin
          cursor <= cursor;
        end else if (byteNew[5]) begin
          mode4 <= ~byteNew[4];
          phase <= 1'b0;
        end else if (byteNew[4]) begin
          cursor <= cursor;
        end else if (byteNew[3]) begin
          dispOn <= byteNew[2];
        end else if (byteNew[2]) begin
          idInc <= byteNew[1];
        end else if (byteNew[1]) begin
          cursor  <= '0;
          busyCnt <= BusyLong;
        end else if (byteNew[0]) begin
          cursor   <= '0;
          idInc    <= 1'b1;
          busyCnt  <= BusyLong;
          state    <= CLEAR;
          clearing <= 1'b1;
          fillIdx  <= '0;
        end
      end
    end
  end

  // Display buffer write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (memWe) mem[memAds] <= memDin;
  end

  // Registered read port; a same-cycle write to the address returns old data.
  always_ff @(posedge clk_i) begin
    if (reset_i) rdData <= 8'h00;
    else         rdData <= mem[bus.rdAds_i];
  end

  assign bus.rdData_o    = rdData;
  assign bus.byteValid_o = byteValid;
  assign bus.byteRs_o    = byteRs;
  assign bus.byte_o      = byteOut;
  assign bus.mode4_o     = mode4;
  assign bus.dispOn_o    = dispOn;
  assign bus.cursorAds_o = cursor;
  assign bus.busyViol_o  = busyViol;
  assign bus.rwViol_o    = rwViol;
  assign bus.clearing_o  = clearing;
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: vector table, directed corner sequences and
// randomized traffic against a behavioural controller model.
module tb_lcd_bus_responder;
  localparam int unsigned BusyShort = 2000;
  localparam int unsigned BusyLong  = 20000;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc;
  int     clrCycles;
  int     nChecks = 0;
  int     nFail   = 0;

  lcd_bus_responder_if bus();

  lcd_bus_responder #(.BUSY_SHORT(BusyShort), .BUSY_LONG(BusyLong)) dut (
    .clk_i(clk), .reset_i(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.clearing_o) clrCycles <= clrCycles + 1;

  // Behavioural model of the controller
  bit         mMode4, mPhase, mId, mDisp;
  bit [3:0]   mHi;
  bit [6:0]   mCur;
  bit [7:0]   mBuf [128];
  longint     mBusyEnd;

  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         gap;
    logic       valid;
    logic [7:0] b;
    logic       mode4;
    logic [6:0] cur;
  } vec_t;
  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Display positions form an 80-entry ring; anything else steps +-1 mod 128.
  function automatic bit [6:0] mStep(input bit [6:0] a, input bit inc);
    int pos;
    if (a <= 7'h27) pos = int'(a);
    else if (a >= 7'h40 && a <= 7'h67) pos = int'(a) - 64 + 40;
    else return inc ? a + 7'd1 : a - 7'd1;
    pos = inc ? (pos + 1) % 80 : (pos + 79) % 80;
    return (pos < 40) ? 7'(pos) : 7'(pos - 40 + 64);
  endfunction

  task automatic mReset();
    mMode4 = 0; mPhase = 0; mId = 1; mDisp = 0; mHi = 0; mCur = 0; mBusyEnd = 0;
  endtask

  task automatic mFall(input bit rs, input bit rw, input bit [3:0] nib, input longint t,
                       output bit done, output bit [7:0] b, output bit viol);
    viol = (t <= mBusyEnd);
    done = 0;
    b    = 8'h00;
    if (rw) begin
      if (mMode4) mPhase = !mPhase;
    end else if (!mMode4) begin
      done = 1; b = {nib, 4'h0};
    end else if (!mPhase) begin
      mHi = nib; mPhase = 1;
    end else begin
      done = 1; b = {mHi, nib}; mPhase = 0;
    end
    if (done) begin
      mBusyEnd = t + longint'(BusyShort);
      if (rs) begin
        mBuf[mCur] = b; mCur = mStep(mCur, mId);
      end else if (b >= 8'h80) mCur = b[6:0];
      else if (b >= 8'h40) mCur = mCur;
      else if (b >= 8'h20) begin mMode4 = !b[4]; mPhase = 0; end
      else if (b >= 8'h10) mCur = mCur;
      else if (b >= 8'h08) mDisp = b[2];
      else if (b >= 8'h04) mId = b[1];
      else if (b >= 8'h02) begin mCur = 0; mBusyEnd = t + longint'(BusyLong); end
      else if (b == 8'h01) begin
        mCur = 0; mId = 1; mBusyEnd = t + longint'(BusyLong);
        foreach (mBuf[i]) mBuf[i] = 8'h20;
      end
    end
  endtask

  // One E pulse; the fall lands 'gap' cycles after the previous fall.
  task automatic xfer(input logic rs, input logic rw, input logic [3:0] nib, input int gap);
    repeat ((gap > 2) ? gap - 2 : 0) @(negedge clk);
    bus.lcdRs_i = rs; bus.lcdRw_i = rw; bus.lcdData_i = nib; bus.lcdE_i = 1'b1;
    @(negedge clk);
    bus.lcdE_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic rs, input logic rw, input logic [3:0] nib, input int gap);
    bit done, viol;
    bit [7:0] b;
    xfer(rs, rw, nib, gap);
    mFall(rs, rw, nib, cyc, done, b, viol);
    chk("valid", 32'(bus.byteValid_o), 32'(done));
    if (done) begin
      chk("byte", 32'(bus.byte_o), 32'(b));
      chk("byteRs", 32'(bus.byteRs_o), 32'(rs));
    end
    chk("busyViol", 32'(bus.busyViol_o), 32'(viol));
    chk("rwViol", 32'(bus.rwViol_o), 32'(rw));
    chk("cursor", 32'(bus.cursorAds_o), 32'(mCur));
    chk("mode4", 32'(bus.mode4_o), 32'(mMode4));
    chk("dispOn", 32'(bus.dispOn_o), 32'(mDisp));
  endtask

  task automatic readBuf(input logic [6:0] a, output logic [7:0] d);
    bus.rdAds_i = a;
    @(negedge clk);
    d = bus.rdData_o;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mReset();
  endtask

  task automatic chkAllZero(input string name);
    chk(name, {bus.byteValid_o, bus.byteRs_o, bus.byte_o, bus.mode4_o, bus.dispOn_o,
               bus.cursorAds_o, bus.busyViol_o, bus.rwViol_o, bus.clearing_o, bus.rdData_o}, 32'h0);
  endtask

  initial begin
    logic [7:0] d;
    int errs;
    int base;
    vecs[0]  = '{1'b0, 4'h3, 2100, 1'b1, 8'h30, 1'b0, 7'h00};
    vecs[1]  = '{1'b0, 4'h3, 2100, 1'b1, 8'h30, 1'b0, 7'h00};
    vecs[2]  = '{1'b0, 4'h3, 2100, 1'b1, 8'h30, 1'b0, 7'h00};
    vecs[3]  = '{1'b0, 4'h2, 2100, 1'b1, 8'h20, 1'b1, 7'h00};
    vecs[4]  = '{1'b0, 4'hC, 2100, 1'b0, 8'h00, 1'b1, 7'h00};
    vecs[5]  = '{1'b0, 4'h3, 2,    1'b1, 8'hC3, 1'b1, 7'h43};
    vecs[6]  = '{1'b1, 4'h4, 2100, 1'b0, 8'h00, 1'b1, 7'h43};
    vecs[7]  = '{1'b1, 4'h1, 2,    1'b1, 8'h41, 1'b1, 7'h44};
    vecs[8]  = '{1'b0, 4'hA, 2100, 1'b0, 8'h00, 1'b1, 7'h44};
    vecs[9]  = '{1'b0, 4'h7, 2,    1'b1, 8'hA7, 1'b1, 7'h27};
    vecs[10] = '{1'b1, 4'h5, 2100, 1'b0, 8'h00, 1'b1, 7'h27};
    vecs[11] = '{1'b1, 4'h8, 2,    1'b1, 8'h58, 1'b1, 7'h40};
    vecs[12] = '{1'b0, 4'hE, 2100, 1'b0, 8'h00, 1'b1, 7'h40};
    vecs[13] = '{1'b0, 4'h7, 2,    1'b1, 8'hE7, 1'b1, 7'h67};
    vecs[14] = '{1'b1, 4'h5, 2100, 1'b0, 8'h00, 1'b1, 7'h67};
    vecs[15] = '{1'b1, 4'h9, 2,    1'b1, 8'h59, 1'b1, 7'h00};
    vecs[16] = '{1'b0, 4'h0, 2100, 1'b0, 8'h00, 1'b1, 7'h00};
    vecs[17] = '{1'b0, 4'h4, 2,    1'b1, 8'h04, 1'b1, 7'h00};
    vecs[18] = '{1'b0, 4'hC, 2100, 1'b0, 8'h00, 1'b1, 7'h00};
    vecs[19] = '{1'b0, 4'h0, 2,    1'b1, 8'hC0, 1'b1, 7'h40};
    vecs[20] = '{1'b1, 4'h5, 2100, 1'b0, 8'h00, 1'b1, 7'h40};
    vecs[21] = '{1'b1, 4'hA, 2,    1'b1, 8'h5A, 1'b1, 7'h27};
    vecs[22] = '{1'b0, 4'h0, 2100, 1'b0, 8'h00, 1'b1, 7'h27};
    vecs[23] = '{1'b0, 4'h6, 2,    1'b1, 8'h06, 1'b1, 7'h27};

    bus.lcdE_i = 1'b0; bus.lcdRs_i = 1'b0; bus.lcdRw_i = 1'b0;
    bus.lcdData_i = 4'h0; bus.rdAds_i = 7'h00;
    repeat (3) @(negedge clk);
    chkAllZero("reset outputs");
    rst = 1'b0;

    // Power-up, positioned write and cursor wrap
    foreach (vecs[i]) begin
      xfer(vecs[i].rs, 1'b0, vecs[i].nib, vecs[i].gap);
      chk($sformatf("vec%0d valid", i), 32'(bus.byteValid_o), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        chk($sformatf("vec%0d byte", i), 32'(bus.byte_o), 32'(vecs[i].b));
        chk($sformatf("vec%0d byteRs", i), 32'(bus.byteRs_o), 32'(vecs[i].rs));
      end
      chk($sformatf("vec%0d busyViol", i), 32'(bus.busyViol_o), 32'h0);
      chk($sformatf("vec%0d mode4", i), 32'(bus.mode4_o), 32'(vecs[i].mode4));
      chk($sformatf("vec%0d cursor", i), 32'(bus.cursorAds_o), 32'(vecs[i].cur));
    end
    readBuf(7'h43, d); chk("read 0x43", 32'(d), 32'h41);
    readBuf(7'h27, d); chk("read 0x27", 32'(d), 32'h58);
    readBuf(7'h67, d); chk("read 0x67", 32'(d), 32'h59);
    readBuf(7'h40, d); chk("read 0x40", 32'(d), 32'h5A);

    // Short busy window: 1000 violates, 2001 does not
    xfer(1'b1, 1'b0, 4'h4, 2100); chk("busy first nib", 32'(bus.busyViol_o), 32'h0);
    xfer(1'b1, 1'b0, 4'h2, 2);    chk("busy lo nib", 32'(bus.busyViol_o), 32'h0);
    xfer(1'b1, 1'b0, 4'h4, 1000); chk("busy gap1000", 32'(bus.busyViol_o), 32'h1);
    xfer(1'b1, 1'b0, 4'h3, 2);    chk("busy gap1000 lo", 32'(bus.busyViol_o), 32'h1);
    xfer(1'b1, 1'b0, 4'h4, 2001); chk("busy gap2001", 32'(bus.busyViol_o), 32'h0);
    xfer(1'b1, 1'b0, 4'h4, 2);

    // Clear with a data write deferred until the fill ends
    xfer(1'b0, 1'b0, 4'h0, 2100);
    base = clrCycles;
    xfer(1'b0, 1'b0, 4'h1, 2);
    chk("clear byte", 32'(bus.byte_o), 32'h01);
    chk("clear clearing", 32'(bus.clearing_o), 32'h1);
    chk("clear cursor", 32'(bus.cursorAds_o), 32'h0);
    xfer(1'b1, 1'b0, 4'h7, 2);    chk("clear wr hi viol", 32'(bus.busyViol_o), 32'h1);
    xfer(1'b1, 1'b0, 4'hE, 2);    chk("clear wr lo viol", 32'(bus.busyViol_o), 32'h1);
    chk("clear wr valid", 32'(bus.byteValid_o), 32'h1);
    chk("clear wr cursor", 32'(bus.cursorAds_o), 32'h1);
    for (int i = 0; i < 400 && bus.clearing_o; i++) @(negedge clk);
    chk("clear ended", 32'(bus.clearing_o), 32'h0);
    chk("clear length", 32'(clrCycles - base), 32'd128);
    @(negedge clk);
    errs = 0;
    for (int a = 0; a < 128; a++) begin
      readBuf(7'(a), d);
      if (d !== ((a == 0) ? 8'h7E : 8'h20)) errs++;
    end
    chk("clear fill contents", 32'(errs), 32'h0);

    // Long busy after clear
    xfer(1'b0, 1'b0, 4'h0, 2100);
    xfer(1'b0, 1'b0, 4'h1, 2);    chk("clear2 clearing", 32'(bus.clearing_o), 32'h1);
    xfer(1'b1, 1'b0, 4'h4, 10000); chk("long busy gap10000", 32'(bus.busyViol_o), 32'h1);

    // Read transfer advances phase; reset mid-byte
    doReset();
    xfer(1'b0, 1'b0, 4'h2, 3);    chk("rw to 4bit", 32'(bus.mode4_o), 32'h1);
    xfer(1'b0, 1'b1, 4'hF, 2100);
    chk("rw pulse", 32'(bus.rwViol_o), 32'h1);
    chk("rw no byte", 32'(bus.byteValid_o), 32'h0);
    xfer(1'b0, 1'b0, 4'h8, 2100); chk("rw phase advanced", 32'(bus.byteValid_o), 32'h1);
    chk("rw pulse cleared", 32'(bus.rwViol_o), 32'h0);
    xfer(1'b1, 1'b0, 4'h4, 2100); chk("midbyte hi", 32'(bus.byteValid_o), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chkAllZero("reset midbyte outputs");
    rst = 1'b0;
    xfer(1'b0, 1'b0, 4'h3, 3);
    chk("post reset 8bit valid", 32'(bus.byteValid_o), 32'h1);
    chk("post reset 8bit byte", 32'(bus.byte_o), 32'h30);
    chk("post reset no viol", 32'(bus.busyViol_o), 32'h0);

    // Randomized traffic against the model
    doReset();
    send(1'b0, 1'b0, 4'h2, 3);
    send(1'b0, 1'b0, 4'h0, 3);
    send(1'b0, 1'b0, 4'h1, 3);
    repeat (200) @(negedge clk);
    for (int n = 0; n < 300; n++) begin
      logic rs, rw;
      logic [3:0] nib;
      int gap;
      rs  = 1'($urandom_range(0, 1));
      nib = 4'($urandom_range(0, 15));
      rw  = ($urandom_range(0, 9) == 0) && (!mMode4 || mPhase);
      gap = ($urandom_range(0, 39) == 0) ? 2100 : int'($urandom_range(2, 6));
      if (!rw && !rs && mMode4 && mPhase && mHi == 4'h0 && nib == 4'h1) nib = 4'h3;
      send(rs, rw, nib, gap);
    end
    @(negedge clk);
    for (int a = 0; a < 128; a++) begin
      readBuf(7'(a), d);
      chk($sformatf("buf[0x%0h]", a), 32'(d), 32'(mBuf[a]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
